player_motion: RTL and testbench

//   Per-player kinematics engine; parametrised successor to the fixed-arc mover.

---
 rtl/player_motion.sv | 269 ++++++++++++++++++++++++++
 tb/tb_player_motion.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// player_motion
//   Per-player kinematics engine: grounded walk, gravity jump, landing
//   recovery and knockback. Positions are wall clamped and, while grounded,
//   kept at least MIN_SEP away from the opponent. All state advances only on
//   the frame tick scen; results appear one clk after the tick.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   scen              frame-tick enable (1-clk pulse)
//   move_left/right   walk direction levels (both high = no direction)
//   jump, knockback   action requests sampled on scen
//   kb_from_right     1: hit came from the right, push left
//   opponent_x        opponent position, for separation and facing
//   pos_x, pos_y      player position (screen y grows downward)
//   vel_y             signed vertical velocity, positive = upward
//   face_right        facing direction
//   airborne          1 while in the AIR state
//   anim_state        IDLE=0 WALK=1 AIR=2 LAND=3 KNOCK=4
//   anim_frame        frame index within the current animation state
//   move_active       1 for the clk after a tick that moved the player
module player_motion #(
    parameter int POS_WIDTH   = 10,
    parameter int START_X     = 40,
    parameter int GROUND_Y    = 400,
    parameter int MIN_X       = 40,
    parameter int MAX_X       = 600,
    parameter int WALK_SPEED  = 2,
    parameter int AIR_SPEED   = 2,
    parameter int JUMP_VEL    = 8,
    parameter int GRAVITY     = 1,
    parameter int LAND_FRAMES = 3,
    parameter int KB_SPEED    = 4,
    parameter int KB_FRAMES   = 6,
    parameter int MIN_SEP     = 32,
    parameter int ANIM_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 scen,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic                 jump,
    input  logic                 knockback,
    input  logic                 kb_from_right,
    input  logic [POS_WIDTH-1:0] opponent_x,
    output logic [POS_WIDTH-1:0] pos_x,
    output logic [POS_WIDTH-1:0] pos_y,
    output logic signed [7:0]    vel_y,
    output logic                 face_right,
    output logic                 airborne,
    output logic [2:0]           anim_state,
    output logic [5:0]           anim_frame,
    output logic                 move_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_AIR   = 3'd2,
        ST_LAND  = 3'd3,
        ST_KNOCK = 3'd4
    } state_t;

    // One extra signed bit lets x steps go below zero before clamping.
    localparam int XW = POS_WIDTH + 1;
    localparam int YW = POS_WIDTH + 2;

    localparam logic signed [XW-1:0] WALK_DX    = XW'(WALK_SPEED);
    localparam logic signed [XW-1:0] AIR_DX     = XW'(AIR_SPEED);
    localparam logic signed [XW-1:0] KB_DX      = XW'(KB_SPEED);
    localparam logic signed [XW-1:0] SEP        = XW'(MIN_SEP);
    localparam logic signed [XW-1:0] LEFT_WALL  = XW'(MIN_X);
    localparam logic signed [XW-1:0] RIGHT_WALL = XW'(MAX_X);
    localparam logic signed [YW-1:0] GROUND     = YW'(GROUND_Y);
    localparam logic [POS_WIDTH-1:0] START_POS  = POS_WIDTH'(START_X);
    localparam logic [POS_WIDTH-1:0] GROUND_POS = POS_WIDTH'(GROUND_Y);
    localparam logic [POS_WIDTH-1:0] MIN_POS    = POS_WIDTH'(MIN_X);
    localparam logic [POS_WIDTH-1:0] MAX_POS    = POS_WIDTH'(MAX_X);
    localparam logic signed [7:0]    JUMP_V     = 8'(JUMP_VEL);
    localparam logic signed [7:0]    GRAV       = 8'(GRAVITY);
    localparam logic [7:0]           LAND_CNT   = 8'(LAND_FRAMES);
    localparam logic [7:0]           KB_CNT     = 8'(KB_FRAMES);
    localparam logic [7:0]           DIV_LAST   = 8'(ANIM_DIV - 1);

    state_t                 state, state_nxt;
    logic [POS_WIDTH-1:0]   pos_x_nxt, pos_y_nxt;
    logic signed [7:0]      vel_y_nxt;
    logic signed [XW-1:0]   dx, dx_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [7:0]             div_cnt;
    logic                   face_nxt;

    logic                   go_left, go_right;
    logic signed [XW-1:0]   cur_x, opp_x;
    logic signed [XW-1:0]   walk_step, air_step, kb_step;
    logic signed [XW-1:0]   step_x, lim_x, sep_x;
    logic signed [YW-1:0]   y_calc;

    assign go_left  = move_left & ~move_right;
    assign go_right = move_right & ~move_left;
    assign cur_x    = $signed({1'b0, pos_x});
    assign opp_x    = $signed({1'b0, opponent_x});

    // Signed step sizes for the current inputs.
    always_comb begin
        walk_step = '0;
        air_step  = '0;
        if (go_right) begin
            walk_step = WALK_DX;
            air_step  = AIR_DX;
        end else if (go_left) begin
            walk_step = -WALK_DX;
            air_step  = -AIR_DX;
        end
        kb_step = kb_from_right ? -KB_DX : KB_DX;
    end

    // Next state and raw (unclamped) motion. Knockback outranks jump and
    // walk; in AIR it only redirects the horizontal drift. dx doubles as
    // the knockback velocity while in KNOCK.
    always_comb begin
        state_nxt = state;
        step_x    = cur_x;
        pos_y_nxt = pos_y;
        vel_y_nxt = vel_y;
        dx_nxt    = dx;
        cnt_nxt   = cnt;
        y_calc    = $signed({2'b00, pos_y}) - {{(YW-8){vel_y[7]}}, vel_y};

        if (state == ST_AIR) begin
            if (knockback) begin
                dx_nxt = kb_step;
                step_x = cur_x + kb_step;
            end else begin
                step_x = cur_x + dx;
            end
            if (y_calc >= GROUND) begin
                pos_y_nxt = GROUND_POS;
                vel_y_nxt = '0;
                state_nxt = ST_LAND;
                cnt_nxt   = LAND_CNT;
            end else begin
                pos_y_nxt = y_calc[POS_WIDTH-1:0];
                vel_y_nxt = vel_y - GRAV;
            end
        end else if (knockback) begin
            state_nxt = ST_KNOCK;
            cnt_nxt   = KB_CNT;
            dx_nxt    = kb_step;
            step_x    = cur_x + kb_step;
        end else begin
            case (state)
                ST_LAND: begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_KNOCK: begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        step_x = cur_x + dx;
                    end
                end
                default: begin
                    if (jump) begin
                        state_nxt = ST_AIR;
                        vel_y_nxt = JUMP_V;
                        dx_nxt    = air_step;
                        step_x    = cur_x + air_step;
                    end else if (go_left || go_right) begin
                        state_nxt = ST_WALK;
                        step_x    = cur_x + walk_step;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Grounded separation: a step toward the opponent may not end closer
    // than MIN_SEP, but a player already inside that distance stays put
    // rather than being pushed out. The wall clamp is applied last.
    always_comb begin
        lim_x = step_x;
        sep_x = step_x;
        if (state != ST_AIR) begin
            if (cur_x < opp_x && step_x > cur_x) begin
                lim_x = opp_x - SEP;
                if (lim_x < cur_x) begin
                    lim_x = cur_x;
                end
                if (sep_x > lim_x) begin
                    sep_x = lim_x;
                end
            end else if (cur_x > opp_x && step_x < cur_x) begin
                lim_x = opp_x + SEP;
                if (lim_x > cur_x) begin
                    lim_x = cur_x;
                end
                if (sep_x < lim_x) begin
                    sep_x = lim_x;
                end
            end
        end
        if (sep_x < LEFT_WALL) begin
            pos_x_nxt = MIN_POS;
        end else if (sep_x > RIGHT_WALL) begin
            pos_x_nxt = MAX_POS;
        end else begin
            pos_x_nxt = sep_x[POS_WIDTH-1:0];
        end
    end

    // Facing tracks the opponent only while grounded and in control.
    always_comb begin
        face_nxt = face_right;
        if (state == ST_IDLE || state == ST_WALK || state == ST_LAND) begin
            if (pos_x < opponent_x) begin
                face_nxt = 1'b1;
            end else if (pos_x > opponent_x) begin
                face_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pos_x       <= START_POS;
            pos_y       <= GROUND_POS;
            vel_y       <= '0;
            dx          <= '0;
            cnt         <= '0;
            face_right  <= 1'b1;
            anim_frame  <= '0;
            div_cnt     <= '0;
            move_active <= 1'b0;
        end else begin
            move_active <= scen && ((pos_x_nxt != pos_x) || (pos_y_nxt != pos_y));
            if (scen) begin
                state      <= state_nxt;
                pos_x      <= pos_x_nxt;
                pos_y      <= pos_y_nxt;
                vel_y      <= vel_y_nxt;
                dx         <= dx_nxt;
                cnt        <= cnt_nxt;
                face_right <= face_nxt;
                // Animation restarts on every state change.
                if (state_nxt != state) begin
                    anim_frame <= '0;
                    div_cnt    <= '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt    <= '0;
                    anim_frame <= anim_frame + 6'd1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

    assign airborne   = (state == ST_AIR);
    assign anim_state = state;

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion
//   Self-checking bench for player_motion. A behavioural model tracks the
//   player from the rules of motion; a compare process checks every DUT
//   output against it on each falling clock edge, and directed scenarios
//   add hand-computed literal expectations.
module tb_player_motion;

    localparam int START_X     = 40;
    localparam int GROUND_Y    = 400;
    localparam int MIN_X       = 40;
    localparam int MAX_X       = 600;
    localparam int WALK_SPEED  = 2;
    localparam int AIR_SPEED   = 2;
    localparam int JUMP_VEL    = 8;
    localparam int GRAVITY     = 1;
    localparam int LAND_FRAMES = 3;
    localparam int KB_SPEED    = 4;
    localparam int KB_FRAMES   = 6;
    localparam int MIN_SEP     = 32;
    localparam int ANIM_DIV    = 4;

    localparam int S_IDLE  = 0;
    localparam int S_WALK  = 1;
    localparam int S_AIR   = 2;
    localparam int S_LAND  = 3;
    localparam int S_KNOCK = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              scen;
    logic              move_left;
    logic              move_right;
    logic              jump;
    logic              knockback;
    logic              kb_from_right;
    logic [9:0]        opponent_x;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic signed [7:0] vel_y;
    logic              face_right;
    logic              airborne;
    logic [2:0]        anim_state;
    logic [5:0]        anim_frame;
    logic              move_active;

    int  testsRun    = 0;
    int  testsFailed = 0;
    bit  checkEn     = 1'b0;

    int  expLeft[5]   = '{42, 40, 40, 40, 40};
    int  expActive[5] = '{1, 1, 0, 0, 0};

    // Model state
    int mX, mY, mVy, mFace, mSt, mCnt, mDx, mInState, mMove;

    always #5 clk = ~clk;

    player_motion dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .scen          (scen),
        .move_left     (move_left),
        .move_right    (move_right),
        .jump          (jump),
        .knockback     (knockback),
        .kb_from_right (kb_from_right),
        .opponent_x    (opponent_x),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .vel_y         (vel_y),
        .face_right    (face_right),
        .airborne      (airborne),
        .anim_state    (anim_state),
        .anim_frame    (anim_frame),
        .move_active   (move_active)
    );

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model of the player, one frame tick at a time.
    always @(posedge clk or negedge reset_n) begin : modelBlk
        int nx, ny, nvy, nst, ncnt, ndx, hdir, kdx, gap, s, a;
        if (!reset_n) begin
            mX <= START_X; mY <= GROUND_Y; mVy <= 0; mFace <= 1; mSt <= S_IDLE;
            mCnt <= 0; mDx <= 0; mInState <= 0; mMove <= 0;
        end else if (!scen) begin
            mMove <= 0;
        end else begin
            hdir = (move_right && !move_left) ? 1 : ((move_left && !move_right) ? -1 : 0);
            kdx  = kb_from_right ? -KB_SPEED : KB_SPEED;
            nx = mX; ny = mY; nvy = mVy; nst = mSt; ncnt = mCnt; ndx = mDx;
            if (mSt == S_AIR) begin
                if (knockback) ndx = kdx;
                nx  = mX + ndx;
                ny  = mY - mVy;
                nvy = mVy - GRAVITY;
                if (ny >= GROUND_Y) begin
                    ny = GROUND_Y; nvy = 0; nst = S_LAND; ncnt = LAND_FRAMES;
                end
            end else if (knockback) begin
                nst = S_KNOCK; ncnt = KB_FRAMES; ndx = kdx; nx = mX + kdx;
            end else if (mSt == S_LAND) begin
                if (mCnt == 1) nst = S_IDLE;
                ncnt = mCnt - 1;
            end else if (mSt == S_KNOCK) begin
                if (mCnt == 1) begin
                    nst = S_IDLE; ncnt = 0;
                end else begin
                    nx = mX + mDx; ncnt = mCnt - 1;
                end
            end else if (jump) begin
                nst = S_AIR; nvy = JUMP_VEL; ndx = hdir * AIR_SPEED; nx = mX + ndx;
            end else begin
                nst = (hdir != 0) ? S_WALK : S_IDLE;
                nx  = mX + hdir * WALK_SPEED;
            end
            // Distance rule: never end a grounded step toward the opponent
            // closer than min(MIN_SEP, current distance).
            s   = nx - mX;
            gap = int'(opponent_x) - mX;
            if (mSt != S_AIR && s != 0 && gap != 0 && ((s > 0) == (gap > 0))) begin
                a = (iabs(gap) < MIN_SEP) ? iabs(gap) : MIN_SEP;
                if (iabs(gap) - iabs(s) < a)
                    nx = (gap > 0) ? int'(opponent_x) - a : int'(opponent_x) + a;
            end
            if (nx < MIN_X) nx = MIN_X;
            if (nx > MAX_X) nx = MAX_X;
            if ((mSt == S_IDLE || mSt == S_WALK || mSt == S_LAND) && mX != int'(opponent_x))
                mFace <= (mX < int'(opponent_x)) ? 1 : 0;
            mInState <= (nst != mSt) ? 0 : mInState + 1;
            mMove    <= ((nx != mX) || (ny != mY)) ? 1 : 0;
            mX <= nx; mY <= ny; mVy <= nvy; mSt <= nst; mCnt <= ncnt; mDx <= ndx;
        end
    end

    // Compare every output with the model each cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pos_x", int'(pos_x), mX);
            checkOutput("pos_y", int'(pos_y), mY);
            checkOutput("vel_y", int'(vel_y), mVy);
            checkOutput("face_right", int'(face_right), mFace);
            checkOutput("airborne", int'(airborne), (mSt == S_AIR) ? 1 : 0);
            checkOutput("anim_state", int'(anim_state), mSt);
            checkOutput("anim_frame", int'(anim_frame), (mInState / ANIM_DIV) % 64);
            checkOutput("move_active", int'(move_active), mMove);
        end
    end

    // One frame tick with the given inputs; returns on the falling edge
    // right after the tick has been registered.
    task automatic applyStimulus(input logic l, input logic r, input logic j,
                                 input logic k, input logic kr);
        @(negedge clk);
        move_left = l; move_right = r; jump = j; knockback = k; kb_from_right = kr;
        scen = 1'b1;
        @(negedge clk);
        scen = 1'b0; jump = 1'b0; knockback = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0; scen = 1'b0; move_left = 1'b0; move_right = 1'b0;
        jump = 1'b0; knockback = 1'b0; kb_from_right = 1'b0; opponent_x = 10'd500;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset pos_x", int'(pos_x), 40);
        checkOutput("reset pos_y", int'(pos_y), 400);
        checkOutput("reset vel_y", int'(vel_y), 0);
        checkOutput("reset face_right", int'(face_right), 1);
        checkOutput("reset anim_state", int'(anim_state), 0);
        checkOutput("reset anim_frame", int'(anim_frame), 0);
        checkOutput("reset move_active", int'(move_active), 0);
        reset_n = 1'b1;

        // Walk right 10 ticks.
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("walk pos_x", int'(pos_x), 60);
        checkOutput("walk anim_state", int'(anim_state), 1);
        checkOutput("walk face_right", int'(face_right), 1);
        checkOutput("walk anim_frame", int'(anim_frame), 2);

        // Walk left into the wall.
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("left pos_x", int'(pos_x), 44);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput("wall pos_x", int'(pos_x), expLeft[i]);
            checkOutput("wall move_active", int'(move_active), expActive[i]);
        end

        // Vertical jump: 17 air ticks, apex 364, 3 landing ticks.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("takeoff anim_state", int'(anim_state), 2);
        checkOutput("takeoff pos_y", int'(pos_y), 400);
        checkOutput("takeoff vel_y", int'(vel_y), 8);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (k == 8 || k == 9) checkOutput("apex pos_y", int'(pos_y), 364);
            if (k < 17) checkOutput("air airborne", int'(airborne), 1);
        end
        checkOutput("land pos_y", int'(pos_y), 400);
        checkOutput("land anim_state", int'(anim_state), 3);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("land hold anim_state", int'(anim_state), 3);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("land exit anim_state", int'(anim_state), 0);

        // Separation against the opponent, then facing flip.
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("approach pos_x", int'(pos_x), 100);
        opponent_x = 10'd140;
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("sep pos_x", int'(pos_x), 108);
        opponent_x = 10'd90;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("flip face_right", int'(face_right), 0);

        // Knockback from the right at x=300.
        for (int i = 0; i < 96; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("kb start pos_x", int'(pos_x), 300);
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("kb pos_x", int'(pos_x), 276);
        checkOutput("kb anim_state", int'(anim_state), 4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("kb exit anim_state", int'(anim_state), 0);
        checkOutput("kb exit pos_x", int'(pos_x), 276);

        // Knockback re-pulsed on its third tick.
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rekb pos_x", int'(pos_x), 244);
        checkOutput("rekb anim_state", int'(anim_state), 4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rekb exit anim_state", int'(anim_state), 0);

        // Knockback from the left while airborne redirects the drift.
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("airkb anim_state", int'(anim_state), 2);
        for (int k = 0; k < 40 && anim_state == 3'd2; k++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("airkb landed", int'(anim_state), 3);
        checkOutput("airkb pos_x", int'(pos_x), 300);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a jump.
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("midair airborne", int'(airborne), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async pos_x", int'(pos_x), 40);
        checkOutput("async pos_y", int'(pos_y), 400);
        checkOutput("async vel_y", int'(vel_y), 0);
        checkOutput("async anim_state", int'(anim_state), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Already inside MIN_SEP: cannot close further, is not pushed.
        opponent_x = 10'd50;
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("close pos_x", int'(pos_x), 40);
        checkOutput("close move_active", int'(move_active), 0);
        checkOutput("close anim_state", int'(anim_state), 1);

        @(negedge clk);
        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
